// File: rtl/apb_reg_slave.sv
// APB responder with NUM_REGS 32-bit read/write registers, fixed wait states and PSLVERR on out-of-range access.
// Optional APB4 byte strobes are enabled by defining APB_PSTRB_EN.
module apb_reg_slave #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDR_WIDTH-1:0]    PADDR,
  input  logic [31:0]              PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [3:0]               PSTRB,
`endif
  output logic [31:0]              PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic [NUM_REGS*32-1:0]   reg_out
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  capture;
  logic                  done;
  logic [IDX_W-1:0]      idx_q;
  logic                  valid_q;
  logic                  write_q;
  logic [31:0]           wdata_q;
  logic [31:0]           wmask;
  logic [31:0]           regs_q [NUM_REGS];
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  addr_valid;

  // Any set bit above the index field pushes word_addr past NUM_REGS.
  assign word_addr  = PADDR >> 2;
  assign addr_valid = (word_addr < ADDR_WIDTH'(NUM_REGS));

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a bare access phase seen in IDLE is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          capture = 1'b1;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (PENABLE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign done = (state_q == ACCESS) && (cnt_q == '0) && PSEL && PENABLE;

  // Setup-phase capture; later bus changes during ACCESS are ignored.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (capture) begin
      idx_q   <= word_addr[IDX_W-1:0];
      valid_q <= addr_valid;
      write_q <= PWRITE;
      wdata_q <= PWDATA;
    end
  end

`ifdef APB_PSTRB_EN
  logic [3:0] strb_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      strb_q <= '0;
    end else if (capture) begin
      strb_q <= PSTRB;
    end
  end

  assign wmask = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};
`else
  assign wmask = '1;
`endif

  // Register file, written on the completion edge of a valid write.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else if (done && write_q && valid_q) begin
      regs_q[idx_q] <= (regs_q[idx_q] & ~wmask) | (wdata_q & wmask);
    end
  end

  assign PREADY  = done;
  assign PSLVERR = done && !valid_q;
  assign PRDATA  = (done && !write_q && valid_q) ? regs_q[idx_q] : 32'h0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave with two wait states and a non-zero reset value.
// Strobe steps are included when APB_PSTRB_EN is defined.
module tb_apb_reg_slave;

  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 12;
  localparam int unsigned WAITS = 2;
  localparam logic [31:0] RV   = 32'hA5A5_0000;

  logic              pclk;
  logic              rst_n;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [31:0]       pwdata;
`ifdef APB_PSTRB_EN
  logic [3:0]        pstrb;
`endif
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic [NREG*32-1:0] reg_out;

  int          n_checks;
  int          n_fail;
  logic [31:0] model [NREG];
  logic [31:0] rd;
  logic        err;
  int          cyc;

  apb_reg_slave #(
    .NUM_REGS(NREG), .ADDR_WIDTH(AW), .WAIT_CYCLES(WAITS), .RESET_VALUE(RV)
  ) dut (
    .PCLK(pclk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr), .reg_out(reg_out)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG*32-1:0] flat();
    logic [NREG*32-1:0] v;
    for (int i = 0; i < NREG; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  // One APB transfer; entered and left 1 time unit after a rising edge.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                      input logic scramble, output logic [31:0] rdata,
                      output logic slverr, output int cycles);
    logic got;
    paddr = addr; pwrite = wr; pwdata = data; psel = 1'b1; penable = 1'b0;
    cycles = 1; rdata = '0; slverr = 1'b0; got = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    if (scramble) begin
      paddr = '0; pwdata = 32'hBAD0_BAD0; pwrite = ~wr;
    end
    while (!got && cycles < 20) begin
      cycles++;
      @(negedge pclk);
      if (pready) begin
        rdata = prdata; slverr = pslverr; got = 1'b1;
      end else begin
        check("prdata_wait", 256'(prdata), 256'(0));
        check("pslverr_wait", 256'(pslverr), 256'(0));
        @(posedge pclk); #1;
      end
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
`ifdef APB_PSTRB_EN
    pstrb = 4'hF;
`endif
    for (int i = 0; i < NREG; i++) model[i] = RV;

    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("rst_pready", 256'(pready), 256'(0));
    check("rst_prdata", 256'(prdata), 256'(0));
    check("rst_pslverr", 256'(pslverr), 256'(0));
    check("rst_regs", 256'(reg_out), 256'(flat()));
    @(posedge pclk); #1;
    rst_n = 1'b1;
    @(posedge pclk); #1;

    // Access phase with no setup must be ignored.
    psel = 1'b1; penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("noset_pready", 256'(pready), 256'(0));
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;

    xfer(1'b1, 12'h004, 32'hDEAD_BEEF, 1'b0, rd, err, cyc);
    model[1] = 32'hDEAD_BEEF;
    check("wr1_cycles", 256'(cyc), 256'(4));
    check("wr1_err", 256'(err), 256'(0));
    check("wr1_reg1", 256'(reg_out[63:32]), 256'(32'hDEAD_BEEF));

    xfer(1'b0, 12'h004, 32'h0, 1'b0, rd, err, cyc);
    check("rd1_data", 256'(rd), 256'(32'hDEAD_BEEF));
    check("rd1_err", 256'(err), 256'(0));
    check("rd1_cycles", 256'(cyc), 256'(4));

    xfer(1'b0, 12'h000, 32'h0, 1'b0, rd, err, cyc);
    check("rd0_reset", 256'(rd), 256'(RV));

    xfer(1'b0, 12'h006, 32'h0, 1'b0, rd, err, cyc);
    check("rd_lowbits", 256'(rd), 256'(32'hDEAD_BEEF));

    xfer(1'b1, 12'h020, 32'h0000_1234, 1'b0, rd, err, cyc);
    check("wr_oob_err", 256'(err), 256'(1));
    check("wr_oob_regs", 256'(reg_out), 256'(flat()));
    xfer(1'b0, 12'h020, 32'h0, 1'b0, rd, err, cyc);
    check("rd_oob_data", 256'(rd), 256'(0));
    check("rd_oob_err", 256'(err), 256'(1));

    xfer(1'b1, 12'h804, 32'h5555_5555, 1'b0, rd, err, cyc);
    check("wr_high_err", 256'(err), 256'(1));
    check("wr_high_regs", 256'(reg_out), 256'(flat()));

    // Bus changes after setup must not affect the transfer.
    xfer(1'b1, 12'h010, 32'hCAFE_F00D, 1'b1, rd, err, cyc);
    model[4] = 32'hCAFE_F00D;
    check("scramble_err", 256'(err), 256'(0));
    check("scramble_regs", 256'(reg_out), 256'(flat()));

    // Abort: PSEL dropped after first access cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h1111_2222;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("abort_pready", 256'(pready), 256'(0));
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (2) begin @(posedge pclk); #1; end
    check("abort_regs", 256'(reg_out), 256'(flat()));
    xfer(1'b1, 12'h008, 32'h0000_0808, 1'b0, rd, err, cyc);
    model[2] = 32'h0000_0808;
    check("after_abort_cycles", 256'(cyc), 256'(4));
    check("after_abort_regs", 256'(reg_out), 256'(flat()));

    // Reset during a wait state.
    xfer(1'b1, 12'h00C, 32'h3333_3333, 1'b0, rd, err, cyc);
    model[3] = 32'h3333_3333;
    check("reg3_written", 256'(reg_out[127:96]), 256'(32'h3333_3333));
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h4444_4444;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) model[i] = RV;
    check("midrst_pready", 256'(pready), 256'(0));
    check("midrst_prdata", 256'(prdata), 256'(0));
    check("midrst_pslverr", 256'(pslverr), 256'(0));
    check("midrst_regs", 256'(reg_out), 256'(flat()));
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    rst_n = 1'b1;
    @(posedge pclk); #1;

    // Back-to-back writes then reads of every register.
    for (int i = 0; i < NREG; i++) begin
      xfer(1'b1, AW'(4*i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 1'b0, rd, err, cyc);
      model[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      check("b2b_wr_err", 256'(err), 256'(0));
    end
    check("b2b_regs", 256'(reg_out), 256'(flat()));
    for (int i = 0; i < NREG; i++) begin
      xfer(1'b0, AW'(4*i), 32'h0, 1'b0, rd, err, cyc);
      check("b2b_rd", 256'(rd), 256'(model[i]));
    end

`ifdef APB_PSTRB_EN
    pstrb = 4'hF;
    xfer(1'b1, 12'h004, 32'hFFFF_FFFF, 1'b0, rd, err, cyc);
    pstrb = 4'b0101;
    xfer(1'b1, 12'h004, 32'h0000_0000, 1'b0, rd, err, cyc);
    check("strb_0101", 256'(reg_out[63:32]), 256'(32'hFF00_FF00));
    pstrb = 4'b0000;
    xfer(1'b1, 12'h004, 32'h1234_5678, 1'b0, rd, err, cyc);
    check("strb_none_err", 256'(err), 256'(0));
    check("strb_none", 256'(reg_out[63:32]), 256'(32'hFF00_FF00));
    xfer(1'b0, 12'h004, 32'h0, 1'b0, rd, err, cyc);
    check("strb_rd", 256'(rd), 256'(32'hFF00_FF00));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
